// File: rtl/loop_nest_scheduler.sv
// loop_nest_scheduler: forwards loop descriptors to the loop controller's
// cfg_loop_iter port, then launches the loop nest tile_count times.
// Optional watchdog on RUN is enabled by defining LOOP_NEST_SCHED_TIMEOUT_EN.
module loop_nest_scheduler #(
  parameter int LOOP_ID_W   = 5,
  parameter int LOOP_ITER_W = 16,
  parameter int TILE_W      = 16,
  parameter int TIMEOUT_W   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef LOOP_NEST_SCHED_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  output logic                   err_timeout,
`endif
  input  logic                   block_start,
  input  logic [TILE_W-1:0]      tile_count,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [LOOP_ID_W-1:0]   desc_loop_id,
  input  logic [LOOP_ITER_W-1:0] desc_iter,
  input  logic                   desc_last,
  output logic                   cfg_loop_iter_v,
  output logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  output logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
  output logic                   ctrl_start,
  input  logic                   ctrl_done,
  output logic                   busy,
  output logic                   block_done,
  output logic [TILE_W-1:0]      tiles_completed,
  output logic                   err_cfg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [TILE_W-1:0]      tiles_left_q;
  logic [TILE_W-1:0]      tiles_done_q;
  logic                   err_cfg_q;
  logic [LOOP_ID_W-1:0]   exp_id_q;
  logic                   cfg_v_q;
  logic [LOOP_ITER_W-1:0] cfg_iter_q;
  logic [LOOP_ID_W-1:0]   cfg_id_q;

  logic accept;
  logic blk_go;
  logic launch_fire;
  logic run_done;
  logic timeout_hit;

  assign accept      = (state_q == S_CFG) && desc_valid;
  assign blk_go      = (state_q == S_IDLE) && block_start;
  assign launch_fire = (state_q == S_LAUNCH) && (tiles_left_q != '0);
  assign run_done    = (state_q == S_RUN) && ctrl_done;

`ifdef LOOP_NEST_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic                 err_tmo_q;

  assign timeout_hit = (state_q == S_RUN) && !ctrl_done &&
                       (timeout_limit != '0) && (tmo_cnt_q == timeout_limit);
  assign err_timeout = err_tmo_q;

  // Watchdog: counts RUN cycles since the last launch; sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err_tmo_q <= 1'b0;
    end else begin
      if (launch_fire)
        tmo_cnt_q <= '0;
      else if (state_q == S_RUN)
        tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
      if (blk_go)
        err_tmo_q <= 1'b0;
      else if (timeout_hit)
        err_tmo_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic for the block sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (block_start) state_d = S_CFG;
      S_CFG:    if (desc_valid && desc_last) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = (tiles_left_q == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (ctrl_done)
          state_d = (tiles_left_q != '0) ? S_GAP : S_DONE;
        else if (timeout_hit)
          state_d = S_DONE;
      end
      S_GAP:    state_d = S_LAUNCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, descriptor forwarding register, id check and tile counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tiles_left_q <= '0;
      tiles_done_q <= '0;
      err_cfg_q    <= 1'b0;
      exp_id_q     <= '0;
      cfg_v_q      <= 1'b0;
      cfg_iter_q   <= '0;
      cfg_id_q     <= '0;
    end else begin
      state_q <= state_d;
      cfg_v_q <= accept;
      if (blk_go) begin
        tiles_left_q <= tile_count;
        tiles_done_q <= '0;
        err_cfg_q    <= 1'b0;
        exp_id_q     <= '0;
      end
      if (accept) begin
        cfg_iter_q <= desc_iter;
        cfg_id_q   <= desc_loop_id;
        exp_id_q   <= exp_id_q + LOOP_ID_W'(1);
        if (desc_loop_id != exp_id_q)
          err_cfg_q <= 1'b1;
      end
      if (launch_fire)
        tiles_left_q <= tiles_left_q - TILE_W'(1);
      if (run_done && (tiles_done_q != '1))
        tiles_done_q <= tiles_done_q + TILE_W'(1);
    end
  end

  assign desc_ready            = (state_q == S_CFG);
  assign busy                  = (state_q != S_IDLE);
  assign block_done            = (state_q == S_DONE);
  assign ctrl_start            = launch_fire;
  assign cfg_loop_iter_v       = cfg_v_q;
  assign cfg_loop_iter         = cfg_iter_q;
  assign cfg_loop_iter_loop_id = cfg_id_q;
  assign tiles_completed       = tiles_done_q;
  assign err_cfg               = err_cfg_q;

endmodule

// File: tb/tb_loop_nest_scheduler.sv
// Testbench for loop_nest_scheduler: per-block timelines are derived from
// descriptor presentation times and controller done delays.
module tb_loop_nest_scheduler;
  localparam int IDW = 5;
  localparam int ITW = 16;
  localparam int TW  = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           block_start;
  logic [TW-1:0]  tile_count;
  logic           desc_valid;
  logic           desc_ready;
  logic [IDW-1:0] desc_loop_id;
  logic [ITW-1:0] desc_iter;
  logic           desc_last;
  logic           cfg_loop_iter_v;
  logic [ITW-1:0] cfg_loop_iter;
  logic [IDW-1:0] cfg_loop_iter_loop_id;
  logic           ctrl_start;
  logic           ctrl_done;
  logic           busy;
  logic           block_done;
  logic [TW-1:0]  tiles_completed;
  logic           err_cfg;
`ifdef LOOP_NEST_SCHED_TIMEOUT_EN
  logic [19:0]    timeout_limit = '0;
  logic           err_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loop_nest_scheduler #(
    .LOOP_ID_W(IDW), .LOOP_ITER_W(ITW), .TILE_W(TW), .TIMEOUT_W(20)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef LOOP_NEST_SCHED_TIMEOUT_EN
    .timeout_limit(timeout_limit), .err_timeout(err_timeout),
`endif
    .block_start(block_start), .tile_count(tile_count),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_loop_id(desc_loop_id), .desc_iter(desc_iter), .desc_last(desc_last),
    .cfg_loop_iter_v(cfg_loop_iter_v), .cfg_loop_iter(cfg_loop_iter),
    .cfg_loop_iter_loop_id(cfg_loop_iter_loop_id),
    .ctrl_start(ctrl_start), .ctrl_done(ctrl_done), .busy(busy),
    .block_done(block_done), .tiles_completed(tiles_completed), .err_cfg(err_cfg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(desc_ready), 0);
    chk({tag, "_cfgv"}, 32'(cfg_loop_iter_v), 0);
    chk({tag, "_cfgiter"}, 32'(cfg_loop_iter), 0);
    chk({tag, "_cfgid"}, 32'(cfg_loop_iter_loop_id), 0);
    chk({tag, "_start"}, 32'(ctrl_start), 0);
    chk({tag, "_bdone"}, 32'(block_done), 0);
    chk({tag, "_tiles"}, 32'(tiles_completed), 0);
    chk({tag, "_errcfg"}, 32'(err_cfg), 0);
  endtask

  // Cycle 0 drives block_start. Descriptor k is presented (valid) in cycle p[k]
  // and written out in p[k]+1. Launch follows two cycles after the last
  // acceptance; each relaunch follows two cycles after a done; block_done
  // follows one cycle after the last done (or three after acceptance if no tiles).
  task automatic run_block(input string tag, input int nt, input int nd,
                           input int ids[4], input int its[4],
                           input int gaps[4], input int dl[8]);
    int p[4];
    int st[8];
    int dn[8];
    int tL, bd, ncomp, kw, kp;
    logic in_run, exp_start, done_now, exp_err;
    p[0] = 1 + gaps[0];
    for (int k = 1; k < nd; k++) p[k] = p[k-1] + 1 + gaps[k];
    tL = p[nd-1];
    if (nt == 0) bd = tL + 3;
    else begin
      st[0] = tL + 2;
      for (int i = 0; i < nt; i++) begin
        dn[i] = st[i] + dl[i];
        if (i + 1 < nt) st[i+1] = dn[i] + 2;
      end
      bd = dn[nt-1] + 1;
    end
    for (int c = 0; c <= bd + 1; c++) begin
      in_run = 1'b0; exp_start = 1'b0; done_now = 1'b0; ncomp = 0;
      for (int i = 0; i < nt; i++) begin
        if (c > st[i] && c <= dn[i]) in_run = 1'b1;
        if (c == st[i]) exp_start = 1'b1;
        if (c == dn[i]) done_now = 1'b1;
        if (dn[i] < c) ncomp++;
      end
      kw = -1; kp = -1; exp_err = 1'b0;
      for (int k = 0; k < nd; k++) begin
        if (p[k] + 1 == c) kw = k;
        if (p[k] == c) kp = k;
        if (ids[k] != k && p[k] < c) exp_err = 1'b1;
      end
      // Drive: legal stimulus plus noise the DUT must ignore.
      block_start = (c == 0) ? 1'b1 : (c <= bd ? 1'($urandom_range(0, 1)) : 1'b0);
      tile_count  = (c == 0) ? TW'(nt) : TW'($urandom);
      desc_valid = 1'b0; desc_last = 1'b0;
      desc_loop_id = IDW'($urandom); desc_iter = ITW'($urandom);
      if (c >= 1 && c <= tL) begin
        if (kp >= 0) begin
          desc_valid = 1'b1; desc_loop_id = IDW'(ids[kp]);
          desc_iter = ITW'(its[kp]); desc_last = (kp == nd - 1);
        end
      end else if (c > tL && c <= bd) begin
        desc_valid = 1'($urandom_range(0, 1)); desc_last = 1'($urandom_range(0, 1));
      end
      if (done_now) ctrl_done = 1'b1;
      else if (in_run || c == 0 || c > bd) ctrl_done = 1'b0;
      else ctrl_done = 1'($urandom_range(0, 1));
      if (c >= 1) begin
        chk({tag, "_busy"}, 32'(busy), 32'(c <= bd));
        chk({tag, "_ready"}, 32'(desc_ready), 32'(c <= tL));
        chk({tag, "_start"}, 32'(ctrl_start), 32'(exp_start));
        chk({tag, "_bdone"}, 32'(block_done), 32'(c == bd));
        chk({tag, "_tiles"}, 32'(tiles_completed), 32'(ncomp));
        chk({tag, "_errcfg"}, 32'(err_cfg), 32'(exp_err));
        chk({tag, "_cfgv"}, 32'(cfg_loop_iter_v), 32'(kw >= 0));
        if (kw >= 0) begin
          chk({tag, "_cfgid"}, 32'(cfg_loop_iter_loop_id), 32'(ids[kw] % 32));
          chk({tag, "_cfgiter"}, 32'(cfg_loop_iter), 32'(its[kw] % 65536));
        end
      end
      step;
    end
  endtask

  initial begin
    int ids[4], its[4], gaps[4], dl[8];
    int nt, nd;
    reset = 1'b1; block_start = 1'b0; tile_count = '0; desc_valid = 1'b0;
    desc_loop_id = '0; desc_iter = '0; desc_last = 1'b0; ctrl_done = 1'b0;
    #1;
    step; step;
    chk_all_zero("reset");
    reset = 1'b0;
    step;

    // Basic nest: 2 tiles, three back-to-back descriptors, done 20 cycles after start.
    run_block("basic", 2, 3, '{0, 1, 2, 0}, '{3, 1, 4, 0}, '{0, 0, 0, 0},
              '{20, 20, 0, 0, 0, 0, 0, 0});
    // Back-pressure: valid gaps of 1-3 cycles.
    for (int k = 0; k < 4; k++) gaps[k] = $urandom_range(1, 3);
    run_block("bp", 2, 3, '{0, 1, 2, 0}, '{3, 1, 4, 0}, gaps,
              '{$urandom_range(1, 9), $urandom_range(1, 9), 0, 0, 0, 0, 0, 0});
    // Out-of-order ids 0,2.
    run_block("badord", 1, 2, '{0, 2, 0, 0}, '{7, 8, 0, 0}, '{0, 0, 0, 0},
              '{5, 0, 0, 0, 0, 0, 0, 0});
    // Zero tiles.
    run_block("zero", 0, 1, '{0, 0, 0, 0}, '{5, 0, 0, 0}, '{0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 0, 0, 0});
    // All-ones tile_count; tiles_completed reaches all-ones.
    for (int i = 0; i < 8; i++) dl[i] = $urandom_range(1, 4);
    run_block("ones", 7, 1, '{0, 0, 0, 0}, '{9, 0, 0, 0}, '{1, 0, 0, 0}, dl);

    // Reset mid-run: abort, ignore later done, then run a fresh block.
    block_start = 1'b1; tile_count = 3; step; block_start = 1'b0;
    desc_valid = 1'b1; desc_loop_id = 0; desc_iter = 9; desc_last = 1'b1; step;
    desc_valid = 1'b0; desc_last = 1'b0;
    chk("rst_flushwr", 32'(cfg_loop_iter_v), 1); step;
    chk("rst_launch", 32'(ctrl_start), 1); step;
    chk("rst_inrun", 32'(busy), 1);
    reset = 1'b1; step; reset = 1'b0;
    chk_all_zero("rst_abort");
    ctrl_done = 1'b1; step; ctrl_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_all_zero("rst_idle");
      step;
    end
    run_block("fresh", 1, 1, '{0, 0, 0, 0}, '{2, 0, 0, 0}, '{0, 0, 0, 0},
              '{3, 0, 0, 0, 0, 0, 0, 0});

    // Randomized blocks.
    for (int b = 0; b < 12; b++) begin
      nt = $urandom_range(0, 7);
      nd = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin
        ids[k]  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : k;
        its[k]  = $urandom_range(0, 65535);
        gaps[k] = $urandom_range(0, 3);
      end
      for (int i = 0; i < 8; i++) dl[i] = $urandom_range(1, 10);
      run_block("rand", nt, nd, ids, its, gaps, dl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/loop_nest_scheduler.md
Name: loop_nest_scheduler

Overview:
Configures and sequences the loop controller FSM for one compute block. It accepts a stream of loop descriptors over a valid/ready handshake and forwards each one to the controller's cfg_loop_iter write port. It then launches the loop nest tile_count times, issuing one start pulse per tile and waiting for each done. It sits between the instruction decoder and the loop controller.

Parameters:
LOOP_ID_W, 5, loop id width; matches controller.
LOOP_ITER_W, 16, loop iteration count width; matches controller.
TILE_W, 16, width of tile_count and tiles_completed.
TIMEOUT_W, 20, watchdog counter width (optional feature only).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
block_start  in  1  start a block; sampled only in IDLE
tile_count  in  TILE_W  number of nest launches; sampled with block_start
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor ready
desc_loop_id  in  LOOP_ID_W  descriptor loop id
desc_iter  in  LOOP_ITER_W  descriptor max iteration value
desc_last  in  1  marks final descriptor of the nest
cfg_loop_iter_v  out  1  controller config write strobe
cfg_loop_iter  out  LOOP_ITER_W  controller config data
cfg_loop_iter_loop_id  out  LOOP_ID_W  controller config address
ctrl_start  out  1  controller start pulse
ctrl_done  in  1  controller done
busy  out  1  high in any state other than IDLE
block_done  out  1  one-cycle pulse at end of block
tiles_completed  out  TILE_W  count of ctrl_done received in the current block
err_cfg  out  1  sticky out-of-order descriptor flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: all outputs 0 and state IDLE. Reset mid-operation aborts immediately; no further cfg writes or ctrl_start are issued.
- States: IDLE, CFG, FLUSH, LAUNCH, RUN, GAP, DONE.
- IDLE: desc_ready=0. On block_start:
  - latch tile_count into tiles_left;
  - clear tiles_completed, err_cfg and the expected-id counter;
  - go to CFG.
- CFG: desc_ready=1.
  - Each accepted descriptor (desc_valid&&desc_ready) is registered.
  - Next cycle, cfg_loop_iter_v=1 with the registered id and iter values (1-cycle latency, at most one write per cycle).
  - desc_valid gaps are allowed.
- CFG id check: expected id starts at 0 and increments per accepted descriptor.
  - If desc_loop_id differs from expected, set err_cfg. The descriptor is still forwarded.
  - err_cfg stays set until the next block_start or reset.
- Leaving CFG: accepting desc_last moves to FLUSH and drops desc_ready that cycle.
- FLUSH: exactly one cycle, during which the final cfg write is driven. This guarantees the controller's last-loop pointer is updated before start.
- LAUNCH:
  - If tiles_left==0, go to DONE with no ctrl_start.
  - Else drive ctrl_start=1 for exactly one cycle, decrement tiles_left, go to RUN.
- RUN: wait for ctrl_done.
  - On ctrl_done, increment tiles_completed.
  - If tiles_left!=0, go to GAP, otherwise go to DONE.
- GAP: one idle cycle so the controller returns to IDLE, then LAUNCH. Loop counters are not rewritten; the controller rezeroes them on wrap.
- DONE: block_done=1 for one cycle, then IDLE.
- Ignored inputs:
  - ctrl_done outside RUN.
  - block_start outside IDLE.
  - desc_valid outside CFG (desc_ready=0 there).
- Counter widths: tiles_completed saturates at all-ones. tile_count of all-ones is legal.

Optional Feature:
Macro: LOOP_NEST_SCHED_TIMEOUT_EN
- Enabled:
  - Adds input timeout_limit [TIMEOUT_W] and output err_timeout.
  - A counter clears on entry to RUN and increments each RUN cycle.
  - When the counter equals timeout_limit without ctrl_done, set err_timeout (sticky until block_start or reset), pulse block_done, and return to IDLE.
  - timeout_limit==0 disables the check.
- Disabled: no extra ports; RUN waits indefinitely.

Test Plan:
- Basic nest:
  - Stimulus: block_start with tile_count=2; descriptors (0,3),(1,1),(2,4,last) back-to-back; model controller asserts done 20 cycles after each start.
  - Response: three cfg writes, each one cycle after its acceptance. ctrl_start one cycle after FLUSH. Second ctrl_start two cycles after the first ctrl_done. block_done one cycle after the second done; tiles_completed=2; err_cfg=0.
- Back-pressure: same descriptors with desc_valid gaps of 1-3 cycles → cfg writes track acceptances 1:1; no start before FLUSH completes.
- Bad order: descriptor ids 0,2 (last) → err_cfg=1 from the cycle after the second acceptance; both writes issued; nest still runs.
- Zero tiles: tile_count=0, one descriptor (0,5,last) → one cfg write; no ctrl_start; block_done 3 cycles after acceptance; tiles_completed=0.
- Reset mid-run: reset asserted in RUN → next cycle all outputs 0; a later ctrl_done is ignored; a fresh block completes normally.
- Timeout (macro on): timeout_limit=50, controller never signals done → err_timeout=1 and block_done pulse 50 cycles into RUN; back in IDLE.
